// File: rtl/pd_sequencer.sv
// Receive-path sequencer for the packet decoder: counts bytes, cross-checks the
// PD byte timer, hands chunk 1 and the full header to SHA, and latches errors.
//
// state    | meaning
// ST_IDLE  | waiting for first byte of a packet
// ST_RECV1 | receiving bytes 2..64, waiting for timer to confirm 64
// ST_RECV2 | receiving bytes 65..80, chunk 1 may still be pending
// ST_HOLD  | full header valid, waiting for header_ack
// ST_ERROR | sticky error, timer held clear until err_clear
module pd_sequencer #(
   parameter int TIMEOUT = 1000,
   parameter int TO_W    = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       byte_valid,
   input  logic       rx_error,
   input  logic       packet_done,
   input  logic       chunk1_ack,
   input  logic       header_ack,
   input  logic       err_clear,
   output logic       cnt_up,
   output logic       clr_cnt,
   output logic       shift_en,
   output logic       chunk1_ready,
   output logic       header_ready,
   output logic       pkt_error,
   output logic [1:0] err_code
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV1 = 3'd1,
      ST_RECV2 = 3'd2,
      ST_HOLD  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   localparam logic [1:0]      ERR_NONE  = 2'b00;
   localparam logic [1:0]      ERR_RX    = 2'b01;
   localparam logic [1:0]      ERR_TO    = 2'b10;
   localparam logic [1:0]      ERR_PROTO = 2'b11;
   localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT);

   state_t          state_q, state_d;
   logic [6:0]      byte_idx_q, byte_idx_d;
   logic [TO_W-1:0] wd_q, wd_d;
   logic            chunk1_q, chunk1_d;
   logic            header_q, header_d;
   logic            clr_q, clr_d;
   logic            pkt_err_q, pkt_err_d;
   logic [1:0]      err_code_q, err_code_d;

   logic            in_recv;
   logic            accept;
   logic            timeout;
   logic [TO_W-1:0] wd_inc;
   logic            err_set;
   logic [1:0]      err_sel;

   always_comb begin
      in_recv = (state_q == ST_RECV1) || (state_q == ST_RECV2);
      accept  = !rst && byte_valid && !rx_error && ((state_q == ST_IDLE) || in_recv);
      wd_inc  = wd_q + TO_W'(1);
      timeout = in_recv && !accept && (wd_inc == TO_LIMIT);
   end

   always_comb begin
      state_d    = state_q;
      byte_idx_d = byte_idx_q;
      wd_d       = '0;
      chunk1_d   = chunk1_q;
      header_d   = 1'b0;
      clr_d      = 1'b0;
      pkt_err_d  = pkt_err_q;
      err_code_d = err_code_q;
      err_set    = 1'b0;
      err_sel    = ERR_NONE;

      if (accept) byte_idx_d = byte_idx_q + 7'd1;
      if (in_recv) wd_d = accept ? '0 : wd_inc;

      case (state_q)
         ST_IDLE: begin
            if (rx_error) begin
               err_set = 1'b1;
               err_sel = ERR_RX;
            end else if (accept) begin
               state_d = ST_RECV1;
            end
         end
         ST_RECV1: begin
            if (rx_error) begin
               err_set = 1'b1;
               err_sel = ERR_RX;
            end else if (timeout) begin
               err_set = 1'b1;
               err_sel = ERR_TO;
            end else if (packet_done) begin
               if (byte_idx_q == 7'd64) begin
                  chunk1_d = 1'b1;
                  state_d  = ST_RECV2;
               end else begin
                  err_set = 1'b1;
                  err_sel = ERR_PROTO;
               end
            end
         end
         ST_RECV2: begin
            if (rx_error) begin
               err_set = 1'b1;
               err_sel = ERR_RX;
            end else if (timeout) begin
               err_set = 1'b1;
               err_sel = ERR_TO;
            end else begin
               if (chunk1_ack) chunk1_d = 1'b0;
               if (accept && (byte_idx_q == 7'd79)) state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // a byte arriving here is an overrun even if the header is acked
            if (byte_valid) begin
               err_set = 1'b1;
               err_sel = ERR_PROTO;
            end else if (header_ack) begin
               state_d    = ST_IDLE;
               byte_idx_d = '0;
               clr_d      = 1'b1;
            end
         end
         ST_ERROR: begin
            if (err_clear) begin
               state_d    = ST_IDLE;
               byte_idx_d = '0;
               pkt_err_d  = 1'b0;
               err_code_d = ERR_NONE;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            byte_idx_d = '0;
         end
      endcase

      if (err_set) begin
         state_d    = ST_ERROR;
         pkt_err_d  = 1'b1;
         err_code_d = err_sel;
      end

      if (state_d == ST_HOLD) header_d = 1'b1;
      if ((state_d == ST_HOLD) || (state_d == ST_ERROR)) chunk1_d = 1'b0;
      if (state_d == ST_ERROR) clr_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         byte_idx_q <= '0;
         wd_q       <= '0;
         chunk1_q   <= 1'b0;
         header_q   <= 1'b0;
         clr_q      <= 1'b0;
         pkt_err_q  <= 1'b0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         byte_idx_q <= byte_idx_d;
         wd_q       <= wd_d;
         chunk1_q   <= chunk1_d;
         header_q   <= header_d;
         clr_q      <= clr_d;
         pkt_err_q  <= pkt_err_d;
         err_code_q <= err_code_d;
      end
   end

   assign cnt_up       = accept;
   assign shift_en     = accept;
   assign clr_cnt      = clr_q;
   assign chunk1_ready = chunk1_q;
   assign header_ready = header_q;
   assign pkt_error    = pkt_err_q;
   assign err_code     = err_code_q;

endmodule

// File: tb/tb_pd_sequencer.sv
// Directed bench for pd_sequencer with a behavioural PD byte timer
// (count cnt_up, clear on clr_cnt/rst, packet_done at 64 and 80).
module tb_pd_sequencer;

   logic       clk;
   logic       rst;
   logic       byte_valid;
   logic       rx_error;
   logic       packet_done;
   logic       chunk1_ack;
   logic       header_ack;
   logic       err_clear;
   logic       cnt_up;
   logic       clr_cnt;
   logic       shift_en;
   logic       chunk1_ready;
   logic       header_ready;
   logic       pkt_error;
   logic [1:0] err_code;

   logic       force_pd;
   logic [6:0] tcnt;
   int         checks;
   int         errors;
   int         ncu;
   int         ncu_save;

   pd_sequencer #(.TIMEOUT(1000), .TO_W(10)) dut (
      .clk          (clk),
      .rst          (rst),
      .byte_valid   (byte_valid),
      .rx_error     (rx_error),
      .packet_done  (packet_done),
      .chunk1_ack   (chunk1_ack),
      .header_ack   (header_ack),
      .err_clear    (err_clear),
      .cnt_up       (cnt_up),
      .clr_cnt      (clr_cnt),
      .shift_en     (shift_en),
      .chunk1_ready (chunk1_ready),
      .header_ready (header_ready),
      .pkt_error    (pkt_error),
      .err_code     (err_code)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      if (rst || clr_cnt) tcnt <= '0;
      else if (cnt_up)    tcnt <= tcnt + 7'd1;
   end

   assign packet_done = force_pd || (tcnt == 7'd64) || (tcnt == 7'd80);

   // Inputs are set just after a negedge; tick lets one posedge consume them.
   task automatic tick();
      #1;
      if (cnt_up) ncu++;
      @(negedge clk);
      byte_valid = 1'b0;
      rx_error   = 1'b0;
      chunk1_ack = 1'b0;
      header_ack = 1'b0;
      err_clear  = 1'b0;
      force_pd   = 1'b0;
   endtask

   task automatic send_byte();
      byte_valid = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      byte_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++; if (cnt_up !== 1'b0) begin errors++; $display("FAIL reset_cnt_up: got %b want 0", cnt_up); end
      checks++; if (shift_en !== 1'b0) begin errors++; $display("FAIL reset_shift_en: got %b want 0", shift_en); end
      checks++; if (chunk1_ready !== 1'b0) begin errors++; $display("FAIL reset_chunk1: got %b want 0", chunk1_ready); end
      checks++; if (header_ready !== 1'b0) begin errors++; $display("FAIL reset_header: got %b want 0", header_ready); end
      checks++; if (pkt_error !== 1'b0) begin errors++; $display("FAIL reset_pkt_error: got %b want 0", pkt_error); end
      checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL reset_err_code: got %b want 00", err_code); end
      checks++; if (clr_cnt !== 1'b0) begin errors++; $display("FAIL reset_clr_cnt: got %b want 0", clr_cnt); end
      byte_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_nominal();
      ncu = 0;
      for (int i = 1; i <= 80; i++) begin
         send_byte();
         if (i == 64) begin
            checks++; if (chunk1_ready !== 1'b0) begin errors++; $display("FAIL nom_c1_early: got %b want 0", chunk1_ready); end
         end
         if (i == 79) begin
            checks++; if (header_ready !== 1'b0) begin errors++; $display("FAIL nom_hdr_early: got %b want 0", header_ready); end
         end
         if (i == 80) begin
            checks++; if (header_ready !== 1'b1) begin errors++; $display("FAIL nom_hdr_rise: got %b want 1", header_ready); end
         end
         for (int g = 0; g < 2; g++) begin
            if (i == 70 && g == 0) chunk1_ack = 1'b1;
            tick();
            if (i == 64 && g == 0) begin
               checks++; if (chunk1_ready !== 1'b1) begin errors++; $display("FAIL nom_c1_rise: got %b want 1", chunk1_ready); end
            end
            if (i == 69 && g == 1) begin
               checks++; if (chunk1_ready !== 1'b1) begin errors++; $display("FAIL nom_c1_hold: got %b want 1", chunk1_ready); end
            end
            if (i == 70 && g == 0) begin
               checks++; if (chunk1_ready !== 1'b0) begin errors++; $display("FAIL nom_c1_ack: got %b want 0", chunk1_ready); end
            end
         end
      end
      checks++; if (ncu !== 80) begin errors++; $display("FAIL nom_cnt_up: got %0d want 80", ncu); end
      header_ack = 1'b1;
      tick();
      checks++; if (header_ready !== 1'b0) begin errors++; $display("FAIL nom_hdr_ack: got %b want 0", header_ready); end
      checks++; if (clr_cnt !== 1'b1) begin errors++; $display("FAIL nom_clr_pulse: got %b want 1", clr_cnt); end
      tick();
      checks++; if (clr_cnt !== 1'b0) begin errors++; $display("FAIL nom_clr_end: got %b want 0", clr_cnt); end
      checks++; if (tcnt !== 7'd0) begin errors++; $display("FAIL nom_timer_clr: got %0d want 0", tcnt); end
   endtask

   task automatic test_back_to_back();
      ncu = 0;
      for (int i = 1; i <= 80; i++) begin
         send_byte();
         if (i == 64) begin
            checks++; if (chunk1_ready !== 1'b0) begin errors++; $display("FAIL b2b_c1_early: got %b want 0", chunk1_ready); end
         end
         if (i >= 65 && i <= 79) begin
            checks++; if (chunk1_ready !== 1'b1) begin errors++; $display("FAIL b2b_c1_pending byte %0d: got %b want 1", i, chunk1_ready); end
         end
         if (i == 79) begin
            checks++; if (header_ready !== 1'b0) begin errors++; $display("FAIL b2b_hdr_early: got %b want 0", header_ready); end
         end
         if (i == 80) begin
            checks++; if (header_ready !== 1'b1) begin errors++; $display("FAIL b2b_hdr_rise: got %b want 1", header_ready); end
            checks++; if (chunk1_ready !== 1'b0) begin errors++; $display("FAIL b2b_c1_hold: got %b want 0", chunk1_ready); end
         end
      end
      checks++; if (ncu !== 80) begin errors++; $display("FAIL b2b_cnt_up: got %0d want 80", ncu); end
      repeat (4) tick();
      chunk1_ack = 1'b1;
      tick();
      checks++; if (header_ready !== 1'b1) begin errors++; $display("FAIL b2b_hdr_stable: got %b want 1", header_ready); end
      header_ack = 1'b1;
      tick();
      checks++; if (clr_cnt !== 1'b1) begin errors++; $display("FAIL b2b_clr_pulse: got %b want 1", clr_cnt); end
      tick();
   endtask

   task automatic test_timeout();
      repeat (10) send_byte();
      repeat (999) tick();
      checks++; if (pkt_error !== 1'b0) begin errors++; $display("FAIL to_early: got %b want 0", pkt_error); end
      tick();
      checks++; if (pkt_error !== 1'b1) begin errors++; $display("FAIL to_pkt_error: got %b want 1", pkt_error); end
      checks++; if (err_code !== 2'b10) begin errors++; $display("FAIL to_err_code: got %b want 10", err_code); end
      checks++; if (clr_cnt !== 1'b1) begin errors++; $display("FAIL to_clr_cnt: got %b want 1", clr_cnt); end
      ncu_save = ncu;
      repeat (3) send_byte();
      checks++; if (ncu !== ncu_save) begin errors++; $display("FAIL to_ignored_bytes: got %0d want %0d", ncu, ncu_save); end
      checks++; if (clr_cnt !== 1'b1) begin errors++; $display("FAIL to_clr_held: got %b want 1", clr_cnt); end
      err_clear = 1'b1;
      tick();
      checks++; if (pkt_error !== 1'b0) begin errors++; $display("FAIL to_clear_flag: got %b want 0", pkt_error); end
      checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL to_clear_code: got %b want 00", err_code); end
      checks++; if (clr_cnt !== 1'b0) begin errors++; $display("FAIL to_clear_clr: got %b want 0", clr_cnt); end
   endtask

   task automatic test_rx_error();
      ncu = 0;
      repeat (29) send_byte();
      byte_valid = 1'b1;
      rx_error   = 1'b1;
      #1;
      checks++; if (cnt_up !== 1'b0) begin errors++; $display("FAIL rx_cnt_up: got %b want 0", cnt_up); end
      checks++; if (shift_en !== 1'b0) begin errors++; $display("FAIL rx_shift_en: got %b want 0", shift_en); end
      tick();
      checks++; if (err_code !== 2'b01) begin errors++; $display("FAIL rx_err_code: got %b want 01", err_code); end
      checks++; if (pkt_error !== 1'b1) begin errors++; $display("FAIL rx_pkt_error: got %b want 1", pkt_error); end
      repeat (5) send_byte();
      checks++; if (ncu !== 29) begin errors++; $display("FAIL rx_cnt_total: got %0d want 29", ncu); end
      err_clear = 1'b1;
      tick();
      checks++; if (pkt_error !== 1'b0) begin errors++; $display("FAIL rx_clear: got %b want 0", pkt_error); end
   endtask

   task automatic test_mismatch();
      repeat (50) send_byte();
      force_pd = 1'b1;
      tick();
      checks++; if (err_code !== 2'b11) begin errors++; $display("FAIL mm_err_code: got %b want 11", err_code); end
      checks++; if (pkt_error !== 1'b1) begin errors++; $display("FAIL mm_pkt_error: got %b want 1", pkt_error); end
      repeat (20) tick();
      checks++; if (chunk1_ready !== 1'b0) begin errors++; $display("FAIL mm_chunk1: got %b want 0", chunk1_ready); end
      err_clear = 1'b1;
      tick();
      checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL mm_clear: got %b want 00", err_code); end
   endtask

   task automatic test_overrun_reset();
      repeat (80) send_byte();
      checks++; if (header_ready !== 1'b1) begin errors++; $display("FAIL ov_hdr: got %b want 1", header_ready); end
      byte_valid = 1'b1;
      header_ack = 1'b1;
      #1;
      checks++; if (cnt_up !== 1'b0) begin errors++; $display("FAIL ov_cnt_up: got %b want 0", cnt_up); end
      tick();
      checks++; if (err_code !== 2'b11) begin errors++; $display("FAIL ov_err_code: got %b want 11", err_code); end
      checks++; if (header_ready !== 1'b0) begin errors++; $display("FAIL ov_hdr_clr: got %b want 0", header_ready); end
      checks++; if (pkt_error !== 1'b1) begin errors++; $display("FAIL ov_pkt_error: got %b want 1", pkt_error); end
      err_clear = 1'b1;
      tick();
      repeat (69) send_byte();
      checks++; if (chunk1_ready !== 1'b1) begin errors++; $display("FAIL rst_pre_c1: got %b want 1", chunk1_ready); end
      byte_valid = 1'b1;
      rst        = 1'b1;
      #1;
      checks++; if (cnt_up !== 1'b0) begin errors++; $display("FAIL rst_cnt_up: got %b want 0", cnt_up); end
      tick();
      checks++; if (chunk1_ready !== 1'b0) begin errors++; $display("FAIL rst_chunk1: got %b want 0", chunk1_ready); end
      checks++; if (header_ready !== 1'b0) begin errors++; $display("FAIL rst_header: got %b want 0", header_ready); end
      checks++; if (pkt_error !== 1'b0) begin errors++; $display("FAIL rst_pkt_error: got %b want 0", pkt_error); end
      checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL rst_err_code: got %b want 00", err_code); end
      checks++; if (clr_cnt !== 1'b0) begin errors++; $display("FAIL rst_clr_cnt: got %b want 0", clr_cnt); end
      rst = 1'b0;
      repeat (64) send_byte();
      tick();
      checks++; if (chunk1_ready !== 1'b1) begin errors++; $display("FAIL rst_restart_c1: got %b want 1", chunk1_ready); end
      checks++; if (pkt_error !== 1'b0) begin errors++; $display("FAIL rst_restart_err: got %b want 0", pkt_error); end
   endtask

   initial begin
      checks     = 0;
      errors     = 0;
      ncu        = 0;
      ncu_save   = 0;
      rst        = 1'b1;
      byte_valid = 1'b0;
      rx_error   = 1'b0;
      chunk1_ack = 1'b0;
      header_ack = 1'b0;
      err_clear  = 1'b0;
      force_pd   = 1'b0;
      test_reset();
      test_nominal();
      test_back_to_back();
      test_timeout();
      test_rx_error();
      test_mismatch();
      test_overrun_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
